// File: rtl/pico_mailbox_fifo_if.sv
// Port-bus bundle for both PicoBlaze processors sharing the mailbox.
// master: processor/bench side, slave: the mailbox.
interface pico_mailbox_fifo_if #(
  parameter int NUM_CH = 2
);
  logic [7:0]        p1_port_id;
  logic [7:0]        p1_out_port;
  logic              p1_write_strobe;
  logic              p1_read_strobe;
  logic [7:0]        p1_in_port;
  logic [7:0]        p2_port_id;
  logic [7:0]        p2_out_port;
  logic              p2_write_strobe;
  logic              p2_read_strobe;
  logic [7:0]        p2_in_port;
  logic [NUM_CH-1:0] p2_irq;

  modport master (
    output p1_port_id, p1_out_port, p1_write_strobe, p1_read_strobe,
    output p2_port_id, p2_out_port, p2_write_strobe, p2_read_strobe,
    input  p1_in_port, p2_in_port, p2_irq
  );

  modport slave (
    input  p1_port_id, p1_out_port, p1_write_strobe, p1_read_strobe,
    input  p2_port_id, p2_out_port, p2_write_strobe, p2_read_strobe,
    output p1_in_port, p2_in_port, p2_irq
  );
endinterface

// File: rtl/pico_mailbox_fifo.sv
// Multi-channel byte mailbox between a producer PicoBlaze (Pico1) and a
// consumer PicoBlaze (Pico2). Each channel is a DEPTH-entry FIFO with sticky
// overflow/underflow flags, flush control and a data-available interrupt.
module pico_mailbox_fifo #(
  parameter int         NUM_CH    = 2,
  parameter int         DEPTH     = 8,
  parameter int         AW        = 3,
  parameter logic [7:0] TX_BASE   = 8'h10,
  parameter logic [7:0] RX_BASE   = 8'h18,
  parameter logic [7:0] STAT_BASE = 8'h20,
  parameter logic [7:0] CNT_BASE  = 8'h30,
  parameter logic [7:0] CTRL_PORT = 8'h28
) (
  input logic                clk,
  input logic                reset,
  pico_mailbox_fifo_if.slave bus
);

  // Flush requests from either side are ORed; bits beyond NUM_CH mean nothing.
  logic [7:0]        ctrl_p1;
  logic [7:0]        ctrl_p2;
  logic [7:0]        ctrl_mask;
  logic [NUM_CH-1:0] flush_mask;

  assign ctrl_p1    = (bus.p1_write_strobe && (bus.p1_port_id == CTRL_PORT)) ? bus.p1_out_port : 8'h00;
  assign ctrl_p2    = (bus.p2_write_strobe && (bus.p2_port_id == CTRL_PORT)) ? bus.p2_out_port : 8'h00;
  assign ctrl_mask  = ctrl_p1 | ctrl_p2;
  assign flush_mask = ctrl_mask[NUM_CH-1:0];

  // Pico1 reads never have side effects, so its read strobe carries no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.p1_read_strobe, ctrl_mask};

  // Per-channel views consumed by the read muxes and the interrupt register.
  logic [7:0]  head_byte      [NUM_CH];
  logic [7:0]  status_byte    [NUM_CH];
  logic [7:0]  count_byte     [NUM_CH];
  logic [AW:0] count_next_arr [NUM_CH];

  logic [NUM_CH-1:0] irq_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [7:0]  TX_PORT    = TX_BASE + 8'(gi);
      localparam logic [7:0]  RX_PORT    = RX_BASE + 8'(gi);
      localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
      localparam logic [AW:0] ALMOST_CNT = (AW+1)'(DEPTH - 1);

      logic [7:0]    mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic [AW:0]   count_next;
      logic          ovf_reg;
      logic          udf_reg;
      logic          push;
      logic          pop;
      logic          flush;
      logic          push_ok;
      logic          pop_ok;

      assign push  = bus.p1_write_strobe && (bus.p1_port_id == TX_PORT);
      assign pop   = bus.p2_read_strobe && (bus.p2_port_id == RX_PORT);
      assign flush = flush_mask[gi];

      // A full channel still takes a push when a pop frees the head slot in the same cycle.
      assign pop_ok  = pop && (count_reg != '0);
      assign push_ok = push && ((count_reg != FULL_CNT) || pop);

      // Occupancy after this edge; flush wins over any same-cycle traffic.
      always_comb begin
        count_next = count_reg;
        if (flush) begin
          count_next = '0;
        end else if (push_ok && !pop_ok) begin
          count_next = count_reg + 1'b1;
        end else if (pop_ok && !push_ok) begin
          count_next = count_reg - 1'b1;
        end
      end

      // Pointer, occupancy and sticky error flag state.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          ovf_reg    <= 1'b0;
          udf_reg    <= 1'b0;
        end else if (flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          ovf_reg    <= 1'b0;
          udf_reg    <= 1'b0;
        end else begin
          if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (push && !push_ok) begin
            ovf_reg <= 1'b1;
          end
          if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          if (pop && !pop_ok) begin
            udf_reg <= 1'b1;
          end
          count_reg <= count_next;
        end
      end

      // Byte storage; deliberately not cleared by reset.
      always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
          mem[wr_ptr_reg] <= bus.p1_out_port;
        end
      end

      assign head_byte[gi]      = mem[rd_ptr_reg];
      assign status_byte[gi]    = {3'b000, udf_reg, ovf_reg, (count_reg >= ALMOST_CNT),
                                   (count_reg == '0), (count_reg == FULL_CNT)};
      assign count_byte[gi]     = 8'(count_reg);
      assign count_next_arr[gi] = count_next;
    end
  endgenerate

  // Interrupt follows the post-edge occupancy of each channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_reg <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        irq_reg[c] <= (count_next_arr[c] != '0);
      end
    end
  end

  assign bus.p2_irq = irq_reg;

  logic [7:0] p1_rdata;
  logic [7:0] p2_rdata;

  // Read muxes: unmapped addresses return zero; only Pico2 sees the FIFO heads.
  always_comb begin
    p1_rdata = 8'h00;
    p2_rdata = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.p1_port_id == (STAT_BASE + 8'(c))) p1_rdata = status_byte[c];
      if (bus.p1_port_id == (CNT_BASE + 8'(c)))  p1_rdata = count_byte[c];
      if (bus.p2_port_id == (STAT_BASE + 8'(c))) p2_rdata = status_byte[c];
      if (bus.p2_port_id == (CNT_BASE + 8'(c)))  p2_rdata = count_byte[c];
      if (bus.p2_port_id == (RX_BASE + 8'(c)))   p2_rdata = head_byte[c];
    end
  end

  assign bus.p1_in_port = p1_rdata;
  assign bus.p2_in_port = p2_rdata;

endmodule

// File: tb/tb_pico_mailbox_fifo.sv
// Self-checking bench for pico_mailbox_fifo (NUM_CH=2, DEPTH=8).
// Expected FIFO bytes are queued per channel as pushes are driven and
// popped for comparison when Pico2 reads them back.
module tb_pico_mailbox_fifo;
  localparam logic [7:0] TX   = 8'h10;
  localparam logic [7:0] RX   = 8'h18;
  localparam logic [7:0] STAT = 8'h20;
  localparam logic [7:0] CNT  = 8'h30;
  localparam logic [7:0] CTRL = 8'h28;
  localparam logic [7:0] NONE = 8'hFF;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  pico_mailbox_fifo_if #(.NUM_CH(2)) bus ();

  pico_mailbox_fifo #(
    .NUM_CH(2), .DEPTH(8), .AW(3),
    .TX_BASE(TX), .RX_BASE(RX), .STAT_BASE(STAT), .CNT_BASE(CNT), .CTRL_PORT(CTRL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.p1_port_id = NONE; bus.p1_out_port = 8'h00;
    bus.p1_write_strobe = 1'b0; bus.p1_read_strobe = 1'b0;
    bus.p2_port_id = NONE; bus.p2_out_port = 8'h00;
    bus.p2_write_strobe = 1'b0; bus.p2_read_strobe = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int ch, input logic [7:0] d);
    if (ch == 0) sb0.push_back(d);
    else         sb1.push_back(d);
  endtask

  task automatic sb_pop(input int ch, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'hxx;
    if (ch == 0 && sb0.size() > 0) begin d = sb0.pop_front(); ok = 1'b1; end
    if (ch == 1 && sb1.size() > 0) begin d = sb1.pop_front(); ok = 1'b1; end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input bit accept);
    bus.p1_port_id = TX + 8'(ch);
    bus.p1_out_port = d;
    bus.p1_write_strobe = 1'b1;
    tick();
    idle();
    if (accept) sb_push(ch, d);
    $display("push ch%0d data %02h", ch, d);
  endtask

  task automatic pop(input int ch, output logic [7:0] d);
    bus.p2_port_id = RX + 8'(ch);
    bus.p2_read_strobe = 1'b1;
    #1;
    d = bus.p2_in_port;
    tick();
    idle();
    $display("pop  ch%0d data %02h", ch, d);
  endtask

  task automatic ctrl(input bit from_p2, input logic [7:0] mask);
    if (from_p2) begin
      bus.p2_port_id = CTRL; bus.p2_out_port = mask; bus.p2_write_strobe = 1'b1;
    end else begin
      bus.p1_port_id = CTRL; bus.p1_out_port = mask; bus.p1_write_strobe = 1'b1;
    end
    tick();
    idle();
    $display("ctrl p%0d mask %02h", from_p2 ? 2 : 1, mask);
  endtask

  task automatic rd1(input logic [7:0] port, output logic [7:0] v);
    bus.p1_port_id = port;
    #1;
    v = bus.p1_in_port;
    bus.p1_port_id = NONE;
    $display("read p1 port %02h data %02h", port, v);
  endtask

  task automatic rd2(input logic [7:0] port, output logic [7:0] v);
    bus.p2_port_id = port;
    #1;
    v = bus.p2_in_port;
    bus.p2_port_id = NONE;
    $display("read p2 port %02h data %02h", port, v);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rd1(STAT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL reset_stat0_p1 got %02h want 02", v); end
    rd2(STAT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL reset_stat0_p2 got %02h want 02", v); end
    rd1(STAT + 8'd1, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL reset_stat1 got %02h want 02", v); end
    rd1(CNT, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_cnt0 got %02h want 00", v); end
    checks++;
    if (bus.p2_irq !== 2'b00) begin errors++; $display("FAIL reset_irq got %b want 00", bus.p2_irq); end
    // Mid-burst asynchronous reset with five bytes queued.
    for (int i = 0; i < 5; i++) push(0, 8'h30 + 8'(i), 1'b1);
    rd1(CNT, v); checks++;
    if (v !== 8'h05) begin errors++; $display("FAIL burst_cnt got %02h want 05", v); end
    reset = 1'b0;
    rd1(CNT, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL async_reset_cnt got %02h want 00", v); end
    checks++;
    if (bus.p2_irq !== 2'b00) begin errors++; $display("FAIL async_reset_irq got %b want 00", bus.p2_irq); end
    reset = 1'b1;
    sb0.delete();
    tick();
  endtask

  task automatic test_fill_drain();
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] e;
    bit ok;
    checks++;
    if (bus.p2_irq[0] !== 1'b0) begin errors++; $display("FAIL irq_before_push got %b want 0", bus.p2_irq[0]); end
    push(0, 8'hA0, 1'b1);
    checks++;
    if (bus.p2_irq[0] !== 1'b1) begin errors++; $display("FAIL irq_after_first_push got %b want 1", bus.p2_irq[0]); end
    for (int i = 1; i < 7; i++) push(0, 8'hA0 + 8'(i), 1'b1);
    rd1(STAT, v); checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL stat_count7 got %02h want 04", v); end
    push(0, 8'hA7, 1'b1);
    rd2(STAT, v); checks++;
    if (v !== 8'h05) begin errors++; $display("FAIL stat_full got %02h want 05", v); end
    rd1(CNT, v); checks++;
    if (v !== 8'h08) begin errors++; $display("FAIL cnt_full got %02h want 08", v); end
    for (int i = 0; i < 8; i++) begin
      pop(0, d);
      sb_pop(0, e, ok);
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL drain_data%0d got %02h want %02h", i, d, e); end
      if (i == 6) begin
        checks++;
        if (bus.p2_irq[0] !== 1'b1) begin errors++; $display("FAIL irq_before_last_pop got %b want 1", bus.p2_irq[0]); end
      end
    end
    checks++;
    if (bus.p2_irq[0] !== 1'b0) begin errors++; $display("FAIL irq_after_last_pop got %b want 0", bus.p2_irq[0]); end
    rd1(STAT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL stat_drained got %02h want 02", v); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] e;
    bit ok;
    for (int i = 0; i < 8; i++) push(0, 8'hA0 + 8'(i), 1'b1);
    push(0, 8'hFF, 1'b0);
    rd1(STAT, v); checks++;
    if (v !== 8'h0D) begin errors++; $display("FAIL stat_ovf got %02h want 0d", v); end
    rd1(CNT, v); checks++;
    if (v !== 8'h08) begin errors++; $display("FAIL cnt_ovf got %02h want 08", v); end
    for (int i = 0; i < 8; i++) begin
      pop(0, d);
      sb_pop(0, e, ok);
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL ovf_data%0d got %02h want %02h", i, d, e); end
    end
    rd1(STAT, v); checks++;
    if (v !== 8'h0A) begin errors++; $display("FAIL ovf_sticky got %02h want 0a", v); end
    ctrl(1'b1, 8'h01);
    rd1(STAT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL ovf_flushed got %02h want 02", v); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] e;
    bit ok;
    for (int i = 0; i < 8; i++) push(0, 8'hB0 + 8'(i), 1'b1);
    bus.p1_port_id = TX; bus.p1_out_port = 8'h55; bus.p1_write_strobe = 1'b1;
    bus.p2_port_id = RX; bus.p2_read_strobe = 1'b1;
    #1;
    d = bus.p2_in_port;
    tick();
    idle();
    $display("push ch0 data 55 with pop ch0 data %02h", d);
    sb_pop(0, e, ok);
    checks++;
    if (!ok || d !== e) begin errors++; $display("FAIL full_pushpop_head got %02h want %02h", d, e); end
    sb_push(0, 8'h55);
    rd1(CNT, v); checks++;
    if (v !== 8'h08) begin errors++; $display("FAIL full_pushpop_cnt got %02h want 08", v); end
    rd1(STAT, v); checks++;
    if (v !== 8'h05) begin errors++; $display("FAIL full_pushpop_stat got %02h want 05", v); end
    for (int i = 0; i < 8; i++) begin
      pop(0, d);
      sb_pop(0, e, ok);
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL full_pushpop_data%0d got %02h want %02h", i, d, e); end
    end
  endtask

  task automatic test_underflow_flush();
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] e;
    bit ok;
    push(0, 8'hC0, 1'b1);
    push(0, 8'hC1, 1'b1);
    pop(1, d);
    rd2(STAT + 8'd1, v); checks++;
    if (v !== 8'h12) begin errors++; $display("FAIL udf_stat1 got %02h want 12", v); end
    rd1(CNT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL udf_cnt0 got %02h want 02", v); end
    ctrl(1'b0, 8'h02);
    rd2(STAT + 8'd1, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL flush1_stat got %02h want 02", v); end
    rd1(CNT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL flush1_cnt0 got %02h want 02", v); end
    ctrl(1'b0, 8'hFC);
    rd1(CNT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL high_mask_cnt0 got %02h want 02", v); end
    for (int i = 0; i < 2; i++) begin
      pop(0, d);
      sb_pop(0, e, ok);
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL udf_ch0_data%0d got %02h want %02h", i, d, e); end
    end
  endtask

  task automatic test_flush_push();
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] e;
    bit ok;
    for (int i = 0; i < 3; i++) push(0, 8'hD0 + 8'(i), 1'b0);
    rd1(CNT, v); checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL pre_flush_cnt got %02h want 03", v); end
    bus.p1_port_id = TX; bus.p1_out_port = 8'hD3; bus.p1_write_strobe = 1'b1;
    bus.p2_port_id = CTRL; bus.p2_out_port = 8'h01; bus.p2_write_strobe = 1'b1;
    tick();
    idle();
    $display("push ch0 data d3 with flush mask 01");
    rd1(CNT, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL flush_push_cnt got %02h want 00", v); end
    rd1(STAT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL flush_push_stat got %02h want 02", v); end
    checks++;
    if (bus.p2_irq[0] !== 1'b0) begin errors++; $display("FAIL flush_push_irq got %b want 0", bus.p2_irq[0]); end
    // Empty channel, simultaneous push and pop: underflow and accepted push.
    bus.p1_port_id = TX; bus.p1_out_port = 8'h77; bus.p1_write_strobe = 1'b1;
    bus.p2_port_id = RX; bus.p2_read_strobe = 1'b1;
    tick();
    idle();
    sb_push(0, 8'h77);
    $display("push ch0 data 77 with pop on empty ch0");
    rd1(STAT, v); checks++;
    if (v !== 8'h10) begin errors++; $display("FAIL empty_pushpop_stat got %02h want 10", v); end
    rd1(CNT, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL empty_pushpop_cnt got %02h want 01", v); end
    pop(0, d);
    sb_pop(0, e, ok);
    checks++;
    if (!ok || d !== e) begin errors++; $display("FAIL empty_pushpop_data got %02h want %02h", d, e); end
    // Both sides flush different channels in the same cycle.
    push(0, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    bus.p1_port_id = CTRL; bus.p1_out_port = 8'h01; bus.p1_write_strobe = 1'b1;
    bus.p2_port_id = CTRL; bus.p2_out_port = 8'h02; bus.p2_write_strobe = 1'b1;
    tick();
    idle();
    $display("ctrl p1 mask 01 with p2 mask 02");
    rd1(CNT, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL or_flush_cnt0 got %02h want 00", v); end
    rd1(CNT + 8'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL or_flush_cnt1 got %02h want 00", v); end
    rd1(STAT, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL or_flush_stat0 got %02h want 02", v); end
  endtask

  task automatic test_interleave();
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] e;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      push(0, 8'hE0 + 8'(i), 1'b1);
      push(1, 8'hF0 + 8'(i), 1'b1);
    end
    rd2(RX + 8'd1, v); checks++;
    if (v !== 8'hF0) begin errors++; $display("FAIL peek_ch1 got %02h want f0", v); end
    rd1(CNT + 8'd1, v); checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL peek_no_pop got %02h want 04", v); end
    bus.p1_port_id = RX; bus.p1_read_strobe = 1'b1;
    #1;
    v = bus.p1_in_port;
    tick();
    idle();
    $display("read p1 port %02h data %02h with strobe", RX, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL p1_rx_read got %02h want 00", v); end
    bus.p2_port_id = TX; bus.p2_out_port = 8'h99; bus.p2_write_strobe = 1'b1;
    tick();
    idle();
    $display("write p2 port %02h data 99", TX);
    rd1(CNT, v); checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL ignored_access_cnt0 got %02h want 04", v); end
    rd1(8'h40, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL unmapped_p1 got %02h want 00", v); end
    rd2(8'h3F, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL unmapped_p2 got %02h want 00", v); end
    for (int i = 0; i < 4; i++) begin
      pop(0, d);
      sb_pop(0, e, ok);
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL inter_ch0_data%0d got %02h want %02h", i, d, e); end
      pop(1, d);
      sb_pop(1, e, ok);
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL inter_ch1_data%0d got %02h want %02h", i, d, e); end
    end
    // A byte pushed at one edge is visible to Pico2 straight after it.
    push(0, 8'h5A, 1'b1);
    rd2(RX, v); checks++;
    if (v !== 8'h5A) begin errors++; $display("FAIL latency_head got %02h want 5a", v); end
    pop(0, d);
    sb_pop(0, e, ok);
    checks++;
    if (!ok || d !== e) begin errors++; $display("FAIL latency_pop got %02h want %02h", d, e); end
    checks++;
    if (bus.p2_irq !== 2'b00) begin errors++; $display("FAIL final_irq got %b want 00", bus.p2_irq); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_underflow_flush();
    test_flush_push();
    test_interleave();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
